// File: rtl/button_mode_ctrl.sv
// Push-button front end: two-flop synchroniser, four-state debounce FSM, 2-bit mode counter
// and a free-running step divider that realigns to every accepted press.
module button_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_DIV        = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic       btn_stable,
    output logic       press,
    output logic [1:0] C,
    output logic       step_en
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic           press_next;
    logic           s1;
    logic           s2;
    logic [DW-1:0]  div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= button;
            s2 <= s1;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press_next = 1'b0;
        case (state)
            S_LOW: begin
                if (s2) begin
                    state_next = S_RISE_CHK;
                    cnt_next   = '0;
                end
            end
            S_RISE_CHK: begin
                if (!s2) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_HIGH;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_HIGH: begin
                if (!s2) begin
                    state_next = S_FALL_CHK;
                    cnt_next   = '0;
                end
            end
            S_FALL_CHK: begin
                if (s2) begin
                    state_next = S_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_LOW;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = S_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // btn_stable is registered from the next state so it moves on the same edge as press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOW;
            cnt        <= '0;
            press      <= 1'b0;
            btn_stable <= 1'b0;
            C          <= 2'd0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            press      <= press_next;
            btn_stable <= (state_next == S_HIGH) || (state_next == S_FALL_CHK);
            if (press_next) begin
                C <= C + 2'd1;
            end
        end
    end

    // A press restarts the step period, so the first tick after a mode change is a full period away
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            step_en <= 1'b0;
        end else if (press_next) begin
            div_cnt <= '0;
            step_en <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            step_en <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
            step_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Directed bench for button_mode_ctrl: press events are predicted into a queue when the
// button is driven and matched (edge number and mode) when press appears.
module tb_button_mode_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;
  localparam int LAT = 3 + DEB;

  logic       clk;
  logic       rst;
  logic       button;
  logic       btn_stable;
  logic       press;
  logic [1:0] c;
  logic       step_en;

  int n_total;
  int n_pass;
  int edge_n;
  int n_press;
  logic [1:0] exp_c;
  logic [31:0] exp_q[$];

  button_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .btn_stable(btn_stable),
    .press(press),
    .C(c),
    .step_en(step_en)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n++;

  // scoreboard: every observed press must match the oldest prediction
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst === 1'b0 && press === 1'b1) begin
      n_press++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL press_unexpected at edge %0d: got press=1 required 0", edge_n);
      end else begin
        e = exp_q.pop_front();
        n_total++;
        if (30'(edge_n) !== e[31:2])
          $display("FAIL press_edge: got edge %0d required %0d", edge_n, e[31:2]);
        else n_pass++;
        n_total++;
        if (c !== e[1:0])
          $display("FAIL press_mode: got C=%0d required %0d", c, e[1:0]);
        else n_pass++;
        n_total++;
        if (btn_stable !== 1'b1)
          $display("FAIL press_stable: got btn_stable=%b required 1", btn_stable);
        else n_pass++;
        n_total++;
        if (step_en !== 1'b0)
          $display("FAIL press_step_excl: got step_en=%b required 0", step_en);
        else n_pass++;
      end
    end
  end

  // driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    button = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_c = 2'd0;
  endtask

  task automatic drive_rise(output int t0);
    button = 1'b1;
    t0 = edge_n;
    exp_c = exp_c + 2'd1;
    exp_q.push_back({30'(t0 + LAT), exp_c});
  endtask

  task automatic release_button(input string tag);
    int t0;
    button = 1'b0;
    t0 = edge_n;
    repeat (LAT - 1) @(negedge clk);
    n_total++;
    if (btn_stable !== 1'b1)
      $display("FAIL %s_release_early: got btn_stable=%b required 1 at edge %0d", tag, btn_stable, edge_n - t0);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (btn_stable !== 1'b0)
      $display("FAIL %s_release: got btn_stable=%b required 0 at edge %0d", tag, btn_stable, edge_n - t0);
    else n_pass++;
  endtask

  task automatic expect_drained(input string tag);
    n_total++;
    if (exp_q.size() !== 0) begin
      $display("FAIL %s_missing_press: got %0d outstanding presses required 0", tag, exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  // scenarios
  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({btn_stable, press, c, step_en} !== 5'b0)
      $display("FAIL reset_outputs: got %b required 00000", {btn_stable, press, c, step_en});
    else n_pass++;
    for (int k = 1; k <= 3 * DIV; k++) begin
      @(negedge clk);
      n_total++;
      if (step_en !== ((k % DIV) == 0))
        $display("FAIL reset_step_en k=%0d: got %b required %b", k, step_en, (k % DIV) == 0);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    int t0;
    apply_reset();
    repeat (3) @(negedge clk);
    drive_rise(t0);
    repeat (LAT) @(negedge clk);
    n_total++;
    if (c !== 2'd1 || btn_stable !== 1'b1)
      $display("FAIL clean_press_state: got C=%0d stable=%b required C=1 stable=1", c, btn_stable);
    else n_pass++;
    for (int k = 1; k <= DIV; k++) begin
      @(negedge clk);
      n_total++;
      if (step_en !== (k == DIV))
        $display("FAIL clean_press_step k=%0d: got %b required %b", k, step_en, k == DIV);
      else n_pass++;
    end
    expect_drained("clean_press");
    release_button("clean_press");
  endtask

  task automatic test_bounce();
    int t0;
    int widths[3] = '{1, 2, 3};
    apply_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      button = 1'b1;
      repeat (widths[i]) @(negedge clk);
      button = 1'b0;
      @(negedge clk);
    end
    drive_rise(t0);
    repeat (LAT + 12) @(negedge clk);
    n_total++;
    if (c !== 2'd1)
      $display("FAIL bounce_mode: got C=%0d required 1", c);
    else n_pass++;
    expect_drained("bounce");
  endtask

  task automatic test_wrap();
    int t0;
    int p0;
    apply_reset();
    repeat (2) @(negedge clk);
    p0 = n_press;
    for (int i = 0; i < 5; i++) begin
      drive_rise(t0);
      repeat (LAT) @(negedge clk);
      n_total++;
      if (c !== exp_c)
        $display("FAIL wrap_mode press %0d: got C=%0d required %0d", i, c, exp_c);
      else n_pass++;
      repeat (3) @(negedge clk);
      if (i < 4) begin
        release_button("wrap");
        repeat (2) @(negedge clk);
      end
    end
    expect_drained("wrap");
    n_total++;
    if (n_press - p0 !== 5)
      $display("FAIL wrap_press_count: got %0d required 5", n_press - p0);
    else n_pass++;
    // asynchronous reset with live state (C=1, btn_stable=1)
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({btn_stable, press, c, step_en} !== 5'b0)
      $display("FAIL async_reset: got %b required 00000", {btn_stable, press, c, step_en});
    else n_pass++;
  endtask

  task automatic test_release_glitch();
    int t0;
    apply_reset();
    repeat (2) @(negedge clk);
    drive_rise(t0);
    repeat (LAT + 3) @(negedge clk);
    button = 1'b0;
    repeat (2) @(negedge clk);
    button = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_total++;
      if (btn_stable !== 1'b1)
        $display("FAIL glitch_stable k=%0d: got %b required 1", k, btn_stable);
      else n_pass++;
    end
    n_total++;
    if (c !== 2'd1)
      $display("FAIL glitch_mode: got C=%0d required 1", c);
    else n_pass++;
    expect_drained("glitch");
  endtask

  task automatic test_reset_mid_debounce();
    int t0;
    apply_reset();
    repeat (2) @(negedge clk);
    button = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (press !== 1'b0 || c !== 2'd0 || btn_stable !== 1'b0)
        $display("FAIL mid_reset_hold k=%0d: got press=%b C=%0d stable=%b required 0/0/0", k, press, c, btn_stable);
      else n_pass++;
    end
    rst = 1'b0;
    exp_c = 2'd0;
    t0 = edge_n;
    exp_c = exp_c + 2'd1;
    exp_q.push_back({30'(t0 + LAT), exp_c});
    repeat (LAT + 6) @(negedge clk);
    n_total++;
    if (c !== 2'd1)
      $display("FAIL mid_reset_mode: got C=%0d required 1", c);
    else n_pass++;
    expect_drained("mid_reset");
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    edge_n = 0;
    n_press = 0;
    exp_c = 2'd0;
    rst = 1'b1;
    button = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_release_glitch();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_mode_ctrl.md
# button_mode_ctrl

Front-end stage feeding the 4-bit feedback shift-register sequence generator. It synchronises and debounces the raw push-button. Each clean press advances the 2-bit mode word `C` that selects the feedback function. It also produces a periodic `step_en` tick that paces the shift register at human-visible speed and realigns to every mode change.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: clock cycles the synchronised input must hold a new level before it is accepted (10 ms at 100 MHz). Legal range ≥ 1.
- `STEP_DIV`, default 50_000_000: period of `step_en` in clock cycles. Legal range ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `button`  in  1  raw, bouncing, asynchronous push-button level
- `btn_stable`  out  1  debounced button level
- `press`  out  1  one-cycle pulse on each accepted rising edge of `btn_stable`
- `C`  out  2  mode word; increments modulo 4 per press
- `step_en`  out  1  one-cycle shift-enable tick for the downstream shift register

## Operation
- Synchroniser: two flops, `button` → `s1` → `s2`. Only `s2` is used downstream. Both flops reset to 0.
- Debounce FSM with counter `cnt`. The counter is wide enough for `DEBOUNCE_CYCLES-1`.
  - S_LOW (`btn_stable`=0): if `s2`=1, go to S_RISE_CHK and set `cnt`←0.
  - S_RISE_CHK (`btn_stable`=0):
    - If `s2`=0, go to S_LOW and set `cnt`←0.
    - Else if `cnt`==`DEBOUNCE_CYCLES-1`, go to S_HIGH, assert `press` and increment `C`.
    - Else `cnt`←`cnt`+1.
  - S_HIGH (`btn_stable`=1): if `s2`=0, go to S_FALL_CHK and set `cnt`←0.
  - S_FALL_CHK (`btn_stable`=1):
    - If `s2`=1, go to S_HIGH.
    - Else if `cnt`==`DEBOUNCE_CYCLES-1`, go to S_LOW.
    - Else `cnt`←`cnt`+1.
  - Release generates no pulse and leaves `C` unchanged.
- `btn_stable` is registered. It is 1 exactly in S_HIGH and S_FALL_CHK.
- `C` is a 2-bit register. Wrap 3→0 is natural 2-bit overflow. No other source modifies `C`.
- Step divider with counter `div_cnt` over 0..`STEP_DIV-1`. On each edge:
  - If the press condition holds this edge: `div_cnt`←0 and `step_en`←0. Press has priority over wrap.
  - Else if `div_cnt`==`STEP_DIV-1`: `div_cnt`←0 and `step_en`←1.
  - Else: `div_cnt`←`div_cnt`+1 and `step_en`←0.
- All outputs are registered. There are no combinational paths from `button` to any output.

## Timing
- Reset value of every output is 0: `btn_stable`, `press`, `C`, `step_en`. FSM resets to S_LOW; `cnt`, `div_cnt`, `s1` and `s2` reset to 0.
- Reset asserted mid-debounce abandons the check. After release, a still-held button is re-qualified from S_LOW and produces a fresh press. Mode is lost to 0.
- Press latency, with edge 1 being the first edge that samples `button`=1 and the button held steady:
  - `press`, the `C` increment and `btn_stable`=1 all update at edge 3+`DEBOUNCE_CYCLES`.
  - `press` is high for exactly one cycle.
- Release latency: `btn_stable`→0 at edge 3+`DEBOUNCE_CYCLES` counted from the first edge that samples 0.
- Any glitch shorter than `DEBOUNCE_CYCLES` consecutive `s2` samples produces no `press` and no `btn_stable` change.
- `step_en` after reset or after a press is first high in the cycle after edge `STEP_DIV`, then every `STEP_DIV` cycles.
- `press` and `step_en` are never high in the same cycle.
- Held button: exactly one press, regardless of hold length.

## Test plan
Directed scenarios, with `DEBOUNCE_CYCLES`=4 and `STEP_DIV`=8:
- Reset: assert `rst` asynchronously mid-cycle → all outputs read 0 immediately. Release, hold `button`=0 → first `step_en` pulse in the cycle after edge 8, then pulses every 8 cycles.
- Clean press: drive `button` 0→1 and hold → `press` is a single pulse after edge 7. `C` 0→1 and `btn_stable`=1 at that same edge. `step_en` is 0 for the next 8 cycles, then pulses.
- Bounce rejection: toggle `button` with high widths of 1, 2 and 3 cycles separated by 1-cycle lows, then hold high → exactly one press, 7 edges after the final rise. `C`=1.
- Wrap: five clean press/release cycles → `C` reads 1, 2, 3, 0, 1, and there are five `press` pulses.
- Release glitch: while in S_HIGH, drop `button` low for 2 cycles, then return high → `btn_stable` stays 1, with no `press` and no `C` change.
- Reset mid-debounce: assert `rst` 2 cycles after the rise while `button` is held → no pulse during reset. After release, `press` fires 7 edges later and `C`=1.
